// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// regfile_scoreboard : NREGS x DATA_W register bank with per-register busy bits
// Rev 1.0
// ============================================================================

module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int NREGS    = 16,
  parameter int ADDR_W   = $clog2(NREGS),
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_ok,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [DATA_W-1:0] rd_data1,
  output logic              rd_busy1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy2,
  output logic [NREGS-1:0]  busy_vec
);

  localparam logic [ADDR_W-1:0] C_ZERO_ADDR = '0;
  localparam bit                C_HAS_ZERO  = (ZERO_REG != 0);
  localparam bit                C_HAS_BYP   = (BYPASS != 0);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  busy_q;
  logic [NREGS-1:0]  busy_d;
  logic              w_wr_live;
  logic              w_rsv_live;
  logic [ADDR_W-1:0] w_rd_addr [2];

  assign w_wr_live  = wr_en && !(C_HAS_ZERO && (wr_addr == C_ZERO_ADDR));
  assign rsv_ok     = rsv_en && (!busy_q[rsv_addr] || (wr_en && (wr_addr == rsv_addr)));
  assign w_rsv_live = rsv_ok && !(C_HAS_ZERO && (rsv_addr == C_ZERO_ADDR));

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (w_wr_live) begin
      regs_d[wr_addr] = wr_data;
      busy_d[wr_addr] = 1'b0;
    end
    // Applied after the writeback clear so a new producer on the same index wins.
    if (w_rsv_live) begin
      busy_d[rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign w_rd_addr[0] = rd_addr1;
  assign w_rd_addr[1] = rd_addr2;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [DATA_W-1:0] rd_data;
    logic              rd_busy;

    always_comb begin
      rd_data = regs_q[w_rd_addr[p]];
      rd_busy = busy_q[w_rd_addr[p]];
      if (C_HAS_BYP && wr_en && (wr_addr == w_rd_addr[p])) begin
        rd_data = wr_data;
        rd_busy = 1'b0;
      end
      // Reset forces zeros even while a bypassed write is on the bus.
      if (!rst_n || (C_HAS_ZERO && (w_rd_addr[p] == C_ZERO_ADDR))) begin
        rd_data = '0;
        rd_busy = 1'b0;
      end
    end
  end

  assign rd_data1 = g_rd[0].rd_data;
  assign rd_busy1 = g_rd[0].rd_busy;
  assign rd_data2 = g_rd[1].rd_data;
  assign rd_busy2 = g_rd[1].rd_busy;
  assign busy_vec = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// tb_regfile_scoreboard : two configurations against a register/busy model
// Rev 1.0
// ============================================================================

module tb_regfile_scoreboard;

  localparam int DW = 32;
  localparam int NR = 16;
  localparam int AW = 4;

  typedef struct {
    logic [DW-1:0] d1;
    logic          b1;
    logic [DW-1:0] d2;
    logic          b2;
    logic          ok;
    logic [NR-1:0] bv;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rsv_en;
  logic [AW-1:0] rsv_addr;
  logic [AW-1:0] rd_addr1;
  logic [AW-1:0] rd_addr2;

  logic          ok_a, rb1_a, rb2_a, ok_b, rb1_b, rb2_b;
  logic [DW-1:0] rd1_a, rd2_a, rd1_b, rd2_b;
  logic [NR-1:0] bv_a, bv_b;

  // Config 0: bypass on, no zero register. Config 1: bypass off, zero register.
  logic [DW-1:0] m_reg  [2][NR];
  logic          m_busy [2][NR];
  exp_t          q0 [$];
  exp_t          q1 [$];
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  regfile_scoreboard #(.DATA_W(DW), .NREGS(NR), .ZERO_REG(0), .BYPASS(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(ok_a),
    .rd_addr1(rd_addr1), .rd_data1(rd1_a), .rd_busy1(rb1_a),
    .rd_addr2(rd_addr2), .rd_data2(rd2_a), .rd_busy2(rb2_a), .busy_vec(bv_a));

  regfile_scoreboard #(.DATA_W(DW), .NREGS(NR), .ZERO_REG(1), .BYPASS(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(ok_b),
    .rd_addr1(rd_addr1), .rd_data1(rd1_b), .rd_busy1(rb1_b),
    .rd_addr2(rd_addr2), .rd_data2(rd2_b), .rd_busy2(rb2_b), .busy_vec(bv_b));

  function automatic void exp_read(input int c, input logic [AW-1:0] a,
                                   output logic [DW-1:0] d, output logic b);
    d = m_reg[c][a];
    b = m_busy[c][a];
    if (c == 0 && wr_en && wr_addr == a) begin
      d = wr_data;
      b = 1'b0;
    end
    if (!rst_n || (c == 1 && a == 0)) begin
      d = '0;
      b = 1'b0;
    end
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Drive one cycle of inputs between edges, predict outputs, then apply the edge to the model.
  task automatic step(input logic r, input logic we, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra,
                      input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    exp_t e;
    logic ok [2];
    rst_n = r; wr_en = we; wr_addr = wa; wr_data = wd;
    rsv_en = re; rsv_addr = ra; rd_addr1 = a1; rd_addr2 = a2;
    if (!r) begin
      for (int c = 0; c < 2; c++)
        for (int i = 0; i < NR; i++) begin
          m_reg[c][i]  = '0;
          m_busy[c][i] = 1'b0;
        end
    end
    for (int c = 0; c < 2; c++) begin
      exp_read(c, a1, e.d1, e.b1);
      exp_read(c, a2, e.d2, e.b2);
      e.ok = re && (!m_busy[c][ra] || (we && wa == ra));
      ok[c] = e.ok;
      for (int i = 0; i < NR; i++) e.bv[i] = m_busy[c][i];
      if (c == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    @(posedge clk);
    if (r) begin
      for (int c = 0; c < 2; c++) begin
        if (we && !(c == 1 && wa == 0)) begin
          m_reg[c][wa]  = wd;
          m_busy[c][wa] = 1'b0;
        end
        if (ok[c] && !(c == 1 && ra == 0)) m_busy[c][ra] = 1'b1;
      end
    end
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("a.rd_data1", rd1_a, e.d1);
      chk("a.rd_busy1", {31'd0, rb1_a}, {31'd0, e.b1});
      chk("a.rd_data2", rd2_a, e.d2);
      chk("a.rd_busy2", {31'd0, rb2_a}, {31'd0, e.b2});
      chk("a.rsv_ok", {31'd0, ok_a}, {31'd0, e.ok});
      chk("a.busy_vec", {16'd0, bv_a}, {16'd0, e.bv});
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("b.rd_data1", rd1_b, e.d1);
      chk("b.rd_busy1", {31'd0, rb1_b}, {31'd0, e.b1});
      chk("b.rd_data2", rd2_b, e.d2);
      chk("b.rd_busy2", {31'd0, rb2_b}, {31'd0, e.b2});
      chk("b.rsv_ok", {31'd0, ok_b}, {31'd0, e.ok});
      chk("b.busy_vec", {16'd0, bv_b}, {16'd0, e.bv});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0; rd_addr1 = '0; rd_addr2 = '0;
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < NR; i++) begin
        m_reg[c][i]  = '0;
        m_busy[c][i] = 1'b0;
      end
    @(posedge clk); #1;
    // Reset, then a plain write and readback
    step(0, 0, 0, 0, 0, 0, 5, 0);
    step(0, 0, 0, 0, 0, 0, 0, 5);
    step(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 5, 5);
    // Reserve, observe busy, writeback clears
    step(1, 0, 0, 0, 1, 3, 0, 3);
    step(1, 0, 0, 0, 0, 0, 1, 3);
    step(1, 1, 3, 32'h12, 0, 0, 3, 3);
    step(1, 0, 0, 0, 0, 0, 3, 3);
    // WAW stall, then same-cycle write lets the new producer in
    step(1, 0, 0, 0, 1, 7, 7, 0);
    step(1, 0, 0, 0, 1, 7, 7, 7);
    step(1, 1, 7, 32'hA5, 1, 7, 7, 7);
    step(1, 0, 0, 0, 0, 0, 7, 7);
    // Bypass on both ports
    step(1, 1, 9, 32'hCAFE, 0, 0, 9, 9);
    step(1, 0, 0, 0, 0, 0, 9, 9);
    // Register 0: write and reserve together
    step(1, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    // Write and reserve to different indices
    step(1, 1, 11, 32'h1111, 1, 12, 11, 12);
    step(1, 0, 0, 0, 0, 0, 11, 12);
    // Reset dropped between edges while state is live
    step(1, 0, 0, 0, 1, 2, 2, 6);
    step(1, 1, 6, 32'h55, 1, 4, 2, 4);
    step(0, 1, 6, 32'h77, 1, 2, 2, 6);
    step(0, 0, 0, 0, 0, 0, 4, 6);
    step(1, 0, 0, 0, 1, 2, 2, 6);
    step(1, 0, 0, 0, 0, 0, 2, 6);
    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      step(($urandom % 150) != 0,
           ($urandom % 3) == 0,
           AW'($urandom_range(0, NR-1)),
           $urandom,
           ($urandom % 2) == 0,
           AW'($urandom_range(0, NR-1)),
           AW'($urandom_range(0, NR-1)),
           AW'($urandom_range(0, NR-1)));
    end
    step(1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); #1;
    if (q0.size() != 0 || q1.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d/%0d pending expected 0/0", q0.size(), q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
